// File: rtl/shift_reg_sr.sv
// WIDTH-bit universal register: hold, load, shift/rotate both ways, masked set/clear,
// with a saturating shift counter and done pulse. Optional parity output via SHIFT_REG_SR_PARITY_EN.
module shift_reg_sr #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  localparam int             CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] notq,
  output logic             sout,
  output logic [CW-1:0]    cnt,
  output logic             done
`ifdef SHIFT_REG_SR_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [WIDTH-1:0] q_nxt_s;
  logic             sout_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic             done_nxt_s;
  logic [CW-1:0]    cnt_inc_s;
  logic             done_hit_s;

  // Saturating increment and the WIDTH-1 -> WIDTH transition that fires done.
  always_comb begin
    if (cnt == CNT_MAX) begin
      cnt_inc_s = CNT_MAX;
    end else begin
      cnt_inc_s = cnt + CW'(1);
    end
    done_hit_s = (cnt == (CNT_MAX - CW'(1)));
  end

  // Next-state decode; every operation works on the pre-edge q.
  always_comb begin
    q_nxt_s    = q;
    sout_nxt_s = sout;
    cnt_nxt_s  = cnt;
    done_nxt_s = 1'b0;
    if (en) begin
      case (mode)
        3'b000: q_nxt_s = q;
        3'b001: begin
          q_nxt_s   = d;
          cnt_nxt_s = {CW{1'b0}};
        end
        3'b010: begin
          q_nxt_s    = {q[WIDTH-2:0], sin};
          sout_nxt_s = q[WIDTH-1];
          cnt_nxt_s  = cnt_inc_s;
          done_nxt_s = done_hit_s;
        end
        3'b011: begin
          q_nxt_s    = {sin, q[WIDTH-1:1]};
          sout_nxt_s = q[0];
          cnt_nxt_s  = cnt_inc_s;
          done_nxt_s = done_hit_s;
        end
        3'b100: begin
          q_nxt_s    = {q[WIDTH-2:0], q[WIDTH-1]};
          sout_nxt_s = q[WIDTH-1];
          cnt_nxt_s  = cnt_inc_s;
          done_nxt_s = done_hit_s;
        end
        3'b101: begin
          q_nxt_s    = {q[0], q[WIDTH-1:1]};
          sout_nxt_s = q[0];
          cnt_nxt_s  = cnt_inc_s;
          done_nxt_s = done_hit_s;
        end
        3'b110: q_nxt_s = q | d;
        3'b111: q_nxt_s = q & ~d;
        default: q_nxt_s = q;
      endcase
    end else begin
      q_nxt_s = q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      q    <= RST_VAL;
      sout <= 1'b0;
      cnt  <= {CW{1'b0}};
      done <= 1'b0;
    end else begin
      q    <= q_nxt_s;
      sout <= sout_nxt_s;
      cnt  <= cnt_nxt_s;
      done <= done_nxt_s;
    end
  end

`ifdef SHIFT_REG_SR_PARITY_EN
  // Parity tracks the registered q by reducing its next state.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      parity <= parity_of(RST_VAL);
    end else begin
      parity <= parity_of(q_nxt_s);
    end
  end
`endif

  assign notq = ~q;

endmodule

// File: tb/tb_shift_reg_sr.sv
// Directed self-checking bench for shift_reg_sr (WIDTH=8, RST_VAL=0).
module tb_shift_reg_sr;

  logic       clk = 1'b0;
  logic       r;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin;
  logic [7:0] q;
  logic [7:0] notq;
  logic       sout;
  logic [3:0] cnt;
  logic       done;
`ifdef SHIFT_REG_SR_PARITY_EN
  logic       parity;
`endif

  int n_cmp = 0;
  int n_err = 0;

  shift_reg_sr #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk(clk), .r(r), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q), .notq(notq), .sout(sout), .cnt(cnt), .done(done)
`ifdef SHIFT_REG_SR_PARITY_EN
    , .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic [7:0] dv, input logic s);
    en = 1'b1; mode = m; d = dv; sin = s;
    step();
  endtask

  initial begin
    logic [7:0] pat;
    int         done_cnt;
    r = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00; sin = 1'b0;
    step();
    step();
    check("rst_q", q, 8'h00);
    check("rst_notq", notq, 8'hFF);
    r = 1'b0;

    // 1. async reset mid-cycle, then enable low holds
    op(3'b001, 8'hA5, 1'b0);
    check("load_a5", q, 8'hA5);
    #2 r = 1'b1;
    #1;
    check("async_q", q, 8'h00);
    check("async_notq", notq, 8'hFF);
    check("async_cnt", cnt, 4'd0);
    check("async_done", done, 1'b0);
    r = 1'b0;
    en = 1'b0; mode = 3'b001; d = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      step();
      check("en0_hold", q, 8'h00);
    end

    // 2. load 0xB4 and shift out left
    op(3'b001, 8'hB4, 1'b0);
    check("ld_b4", q, 8'hB4);
    check("ld_b4_cnt", cnt, 4'd0);
    pat = 8'hB4;
    for (int i = 0; i < 8; i++) begin
      op(3'b010, 8'h00, 1'b0);
      check("shl_sout", sout, pat[7-i]);
      check("shl_cnt", cnt, i + 1);
      check("shl_done", done, (i == 7) ? 1'b1 : 1'b0);
    end
    check("shl_q", q, 8'h00);
    op(3'b010, 8'h00, 1'b0);
    check("sat_cnt", cnt, 4'd8);
    check("sat_done", done, 1'b0);

    // 3. deserialise right
    op(3'b001, 8'h00, 1'b0);
    pat = 8'b1001_1101;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      op(3'b011, 8'h00, pat[7-i]);
      if (done) done_cnt++;
    end
    check("shr_q", q, 8'hB9);
    check("shr_done_now", done, 1'b1);
    check("shr_done_cnt", done_cnt, 1);

    // 4. rotate
    op(3'b001, 8'h81, 1'b0);
    op(3'b100, 8'h00, 1'b0);
    check("rol_q", q, 8'h03);
    check("rol_sout", sout, 1'b1);
    op(3'b101, 8'h00, 1'b0);
    check("ror1_q", q, 8'h81);
    op(3'b101, 8'h00, 1'b0);
    check("ror2_q", q, 8'hC0);
    check("ror2_sout", sout, 1'b1);
    check("ror2_cnt", cnt, 4'd3);

    // 5. set / clear masks
    op(3'b001, 8'h0F, 1'b0);
    op(3'b110, 8'hF0, 1'b0);
    check("set_q", q, 8'hFF);
    check("set_cnt", cnt, 4'd0);
    check("set_sout", sout, 1'b1);
    op(3'b111, 8'h3C, 1'b0);
    check("clr_q", q, 8'hC3);
    check("clr_notq", notq, 8'h3C);
    check("clr_sout", sout, 1'b1);
    op(3'b110, 8'h00, 1'b0);
    check("set0_q", q, 8'hC3);
    op(3'b111, 8'h00, 1'b0);
    check("clr0_q", q, 8'hC3);
    check("clr0_cnt", cnt, 4'd0);

    // 6. load wins over the completing shift
    op(3'b001, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) op(3'b010, 8'h00, 1'b1);
    check("pre_cnt", cnt, 4'd7);
    check("pre_q", q, 8'h7F);
    op(3'b001, 8'h55, 1'b0);
    check("abort_q", q, 8'h55);
    check("abort_cnt", cnt, 4'd0);
    check("abort_done", done, 1'b0);
    en = 1'b0;
    step();
    check("abort_done2", done, 1'b0);
`ifdef SHIFT_REG_SR_PARITY_EN
    check("par_55", parity, 1'b0);
    op(3'b111, 8'h01, 1'b0);
    check("par_q54", q, 8'h54);
    check("par_54", parity, 1'b1);
`endif

    // reset during serialisation aborts with no done
    op(3'b001, 8'hFF, 1'b0);
    for (int i = 0; i < 7; i++) op(3'b010, 8'h00, 1'b0);
    r = 1'b1;
    step();
    check("rst_mid_cnt", cnt, 4'd0);
    check("rst_mid_sout", sout, 1'b0);
    r = 1'b0;
    op(3'b010, 8'h00, 1'b0);
    check("post_rst_cnt", cnt, 4'd1);
    check("post_rst_done", done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
